// File: rtl/mac_dot_sequencer.sv
// Operand-pair FIFO and sequencer that streams dot-product vectors into a 16-bit MAC.
// Each result is returned with its pair count and a timeout error flag.
module mac_dot_sequencer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DRAIN_CYC = 8,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    input  logic                     in_last,
    output logic                     mac_en,
    output logic signed [DATA_W-1:0] mac_a,
    output logic signed [DATA_W-1:0] mac_b,
    output logic                     mac_finalize,
    input  logic signed [ACC_W-1:0]  mac_out,
    input  logic                     mac_out_valid,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data,
    output logic [CNT_W-1:0]         res_count,
    output logic                     res_err,
    output logic                     busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned DRN_W = $clog2(DRAIN_CYC + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic                     last;
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_FINAL,
        ST_WAIT_RES,
        ST_HOLD
    } state_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               in_ready_q;
    logic               push, pop, fifo_empty;
    entry_t             head;

    state_t             state_q;
    logic [CNT_W-1:0]   pair_cnt_q;
    logic [DRN_W-1:0]   drain_q;
    logic [TMO_W-1:0]   wait_q;
    logic               mac_en_q, mac_fin_q;
    logic signed [DATA_W-1:0] mac_a_q, mac_b_q;
    logic               res_valid_q, res_err_q, busy_q;
    logic signed [ACC_W-1:0]  res_data_q;
    logic [CNT_W-1:0]   res_count_q;

    assign fifo_empty = (occ_q == '0);
    assign push       = in_valid && in_ready_q;
    assign pop        = (state_q == ST_STREAM) && !fifo_empty;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage array carries no reset; emptiness is tracked by the occupancy counter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{last: in_last, a: in_a, b: in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            occ_q      <= occ_d;
            in_ready_q <= (occ_d != OCC_W'(DEPTH));
        end
    end

    // Sequencer: the wait counter starts at the finalize edge so an unanswered vector
    // completes exactly TIMEOUT cycles after mac_finalize rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pair_cnt_q  <= '0;
            drain_q     <= '0;
            wait_q      <= '0;
            mac_en_q    <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_fin_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mac_en_q  <= 1'b0;
            mac_a_q   <= '0;
            mac_b_q   <= '0;
            mac_fin_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_q    <= ST_STREAM;
                        pair_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (pop) begin
                        mac_en_q <= 1'b1;
                        mac_a_q  <= head.a;
                        mac_b_q  <= head.b;
                        if (pair_cnt_q != '1) pair_cnt_q <= pair_cnt_q + CNT_W'(1);
                        if (head.last) begin
                            state_q <= ST_DRAIN;
                            drain_q <= DRN_W'(DRAIN_CYC - 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) begin
                        mac_fin_q <= 1'b1;
                        wait_q    <= '0;
                        state_q   <= ST_FINAL;
                    end else begin
                        drain_q <= drain_q - DRN_W'(1);
                    end
                end
                ST_FINAL: begin
                    wait_q  <= wait_q + TMO_W'(1);
                    state_q <= ST_WAIT_RES;
                end
                ST_WAIT_RES: begin
                    if (mac_out_valid) begin
                        res_data_q  <= mac_out;
                        res_err_q   <= 1'b0;
                        res_count_q <= pair_cnt_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else if (wait_q == TMO_W'(TIMEOUT - 1)) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_count_q <= pair_cnt_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else begin
                        wait_q <= wait_q + TMO_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign mac_en       = mac_en_q;
    assign mac_a        = mac_a_q;
    assign mac_b        = mac_b_q;
    assign mac_finalize = mac_fin_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_count    = res_count_q;
    assign res_err      = res_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer with a behavioural MAC that can be told to stay silent.
module tb_mac_dot_sequencer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned CNT_W  = 16;

    logic                     clk, rst_n;
    logic                     in_valid, in_ready, in_last;
    logic signed [DATA_W-1:0] in_a, in_b;
    logic                     mac_en, mac_finalize, mac_out_valid;
    logic signed [DATA_W-1:0] mac_a, mac_b;
    logic signed [ACC_W-1:0]  mac_out;
    logic                     res_valid, res_ready, res_err, busy;
    logic signed [ACC_W-1:0]  res_data;
    logic [CNT_W-1:0]         res_count;

    mac_dot_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_finalize(mac_finalize),
        .mac_out(mac_out), .mac_out_valid(mac_out_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_count(res_count), .res_err(res_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    typedef struct { longint a; longint b; } pair_t;
    typedef struct { longint data; longint cnt; longint err; } res_t;
    pair_t  exp_pairs[$];
    res_t   exp_res[$];
    int     en_log[$];
    longint vsum = 0;
    longint vcnt = 0;

    // MAC model: accumulates on en, reports on the cycle after finalize when allowed.
    bit     mac_respond = 1'b1;
    longint acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= 0;
            mac_out_valid <= 1'b0;
            mac_out       <= '0;
        end else begin
            mac_out_valid <= 1'b0;
            if (mac_en) acc <= acc + longint'(mac_a) * longint'(mac_b);
            if (mac_finalize) begin
                acc <= 0;
                if (mac_respond) begin
                    mac_out_valid <= 1'b1;
                    mac_out       <= ACC_W'(acc);
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit log_en      = 1'b0;
    bit exp_timeout = 1'b0;
    bit rv_prev     = 1'b0;
    int last_en_cyc = 0;
    int fin_cyc     = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mac_en) begin
                last_en_cyc = cyc;
                if (log_en) en_log.push_back(cyc);
                if (exp_pairs.size() == 0) begin
                    check("pair_queue_depth", longint'(exp_pairs.size()), 1);
                end else begin
                    pair_t p;
                    p = exp_pairs.pop_front();
                    check("mac_a", longint'(mac_a), p.a);
                    check("mac_b", longint'(mac_b), p.b);
                end
            end else if (log_en && busy) begin
                check("bubble_a", longint'(mac_a), 0);
                check("bubble_b", longint'(mac_b), 0);
            end
            if (mac_finalize) begin
                fin_cyc = cyc;
                check("drain_gap", longint'(fin_cyc - last_en_cyc), 8);
            end
            if (res_valid && !rv_prev && exp_timeout)
                check("timeout_latency", longint'(cyc - fin_cyc), 64);
            rv_prev = res_valid;
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) begin
                    check("res_queue_depth", longint'(exp_res.size()), 1);
                end else begin
                    res_t r;
                    r = exp_res.pop_front();
                    check("res_data",  longint'(res_data),  r.data);
                    check("res_count", longint'(res_count), r.cnt);
                    check("res_err",   longint'(res_err),   r.err);
                end
            end
        end else begin
            rv_prev = 1'b0;
        end
    end

    task automatic push(input longint a, input longint b, input bit last);
        int   n;
        res_t r;
        n        = 0;
        in_a     = DATA_W'(a);
        in_b     = DATA_W'(b);
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check("push_wait_bound", longint'(n), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_pairs.push_back('{a, b});
        vsum += a * b;
        vcnt++;
        if (last) begin
            if (mac_respond) r = '{vsum, vcnt, 0};
            else             r = '{0, vcnt, 1};
            exp_res.push_back(r);
            vsum = 0;
            vcnt = 0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_res.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_bound", longint'(n < 2000), 1);
        check("pairs_left", longint'(exp_pairs.size()), 0);
    endtask

    task automatic wait_res_valid();
        int n;
        n = 0;
        while (!res_valid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("res_valid_bound", longint'(n < 500), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_mac_en", longint'(mac_en), 0);
        check("rst_finalize", longint'(mac_finalize), 0);
        check("rst_res_valid", longint'(res_valid), 0);
        check("rst_busy", longint'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic vector with consecutive enables
        log_en = 1'b1;
        en_log.delete();
        push(10, 5, 0); push(6, 7, 0); push(3, 4, 1);
        drain();
        check("t1_en_count", longint'(en_log.size()), 3);
        if (en_log.size() == 3) check("t1_en_span", longint'(en_log[2] - en_log[0]), 2);

        // Signed operands
        log_en = 1'b0;
        push(-3, 4, 0); push(2, -5, 1);
        drain();

        // Input gap produces bubbles
        log_en = 1'b1;
        en_log.delete();
        push(1, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        push(2, 2, 1);
        drain();
        check("t4_en_count", longint'(en_log.size()), 2);
        if (en_log.size() == 2) check("t4_en_gap", longint'(en_log[1] - en_log[0]), 3);
        log_en = 1'b0;

        // FIFO fills while a result is held
        res_ready = 1'b0;
        push(1, 2, 1);
        wait_res_valid();
        for (int i = 1; i <= 16; i++) push(longint'(i) - 8, 3 * longint'(i), i == 16);
        check("full_in_ready", longint'(in_ready), 0);
        in_a = 16'sd99; in_b = 16'sd99; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("full_still_blocked", longint'(in_ready), 0);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        drain();

        // MAC never answers
        mac_respond = 1'b0;
        exp_timeout = 1'b1;
        push(7, 7, 1);
        drain();
        exp_timeout = 1'b0;
        mac_respond = 1'b1;

        // Reset in the middle of streaming
        res_ready = 1'b0;
        push(5, 5, 1);
        wait_res_valid();
        for (int i = 0; i < 4; i++) push(1, 1, 0);
        res_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!mac_en && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("stream_start_bound", longint'(n < 100), 1);
        end
        rst_n = 1'b0;
        #1;
        check("abort_mac_en", longint'(mac_en), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_in_ready", longint'(in_ready), 1);
        check("abort_res_valid", longint'(res_valid), 0);
        exp_pairs.delete();
        exp_res.delete();
        vsum = 0;
        vcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_abort_res_valid", longint'(res_valid), 0);
        check("post_abort_busy", longint'(busy), 0);
        check("post_abort_in_ready", longint'(in_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
